// File: rtl/decode_queue.sv
// decode_queue: small circular FIFO between the decode mux and the next stage.
//
// Ports
//   clock_i, reset_i         rising-edge clock, asynchronous active-low reset
//   enable_i                 push strobe; all payload *_i fields are captured together
//   flush_i                  synchronous discard of every entry (overrides push/pop)
//   ready_i                  downstream takes the head entry this cycle
//   valid_o                  a head entry is present
//   *_o payload              head entry, driven straight from storage; zero when empty
//   stall_o                  upstream should stop pushing (one slot of slack remains)
//   count_o                  number of occupied entries
//   overflow_o               sticky: a push was dropped because the queue was full
//
// Handshake: the head entry transfers on a rising edge where valid_o and ready_i
// are both high; valid_o does not depend on ready_i, and ready_i is ignored
// while the queue is empty. A push while full is accepted only if a pop happens
// on the same edge, otherwise it is dropped and overflow_o is raised.
module decode_queue #(
  parameter int unsigned depth                   = 4,
  parameter int unsigned addressWidth            = 64,
  parameter int unsigned opcodeSize              = 12,
  parameter int unsigned funcUnitCodeSize        = 3,
  parameter int unsigned formatWidth             = 25,
  parameter int unsigned bodyWidth               = 64,
  parameter int unsigned instructionCounterWidth = 64,
  parameter int unsigned instMinIdWidth          = 7,
  parameter int unsigned PidSize                 = 20,
  parameter int unsigned TidSize                 = 16,
  parameter int unsigned regAccessPatternSize    = 2
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [formatWidth-1:0]             instFormat_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            address_i,
  input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
  input  logic [instructionCounterWidth-1:0] majID_i,
  input  logic [instMinIdWidth-1:0]          minID_i,
  input  logic [instMinIdWidth-1:0]          numMicroOps_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic [regAccessPatternSize-1:0]    op1rw_i,
  input  logic [regAccessPatternSize-1:0]    op2rw_i,
  input  logic [regAccessPatternSize-1:0]    op3rw_i,
  input  logic [regAccessPatternSize-1:0]    op4rw_i,
  input  logic                               op1IsReg_i,
  input  logic                               op2IsReg_i,
  input  logic                               op3IsReg_i,
  input  logic                               op4IsReg_i,
  input  logic [bodyWidth-1:0]               body_i,
  input  logic                               flush_i,
  input  logic                               ready_i,
  output logic                               valid_o,
  output logic                               stall_o,
  output logic [$clog2(depth):0]             count_o,
  output logic                               overflow_o,
  output logic [formatWidth-1:0]             instFormat_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [addressWidth-1:0]            address_o,
  output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
  output logic [instructionCounterWidth-1:0] majID_o,
  output logic [instMinIdWidth-1:0]          minID_o,
  output logic [instMinIdWidth-1:0]          numMicroOps_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic [regAccessPatternSize-1:0]    op1rw_o,
  output logic [regAccessPatternSize-1:0]    op2rw_o,
  output logic [regAccessPatternSize-1:0]    op3rw_o,
  output logic [regAccessPatternSize-1:0]    op4rw_o,
  output logic                               op1IsReg_o,
  output logic                               op2IsReg_o,
  output logic                               op3IsReg_o,
  output logic                               op4IsReg_o,
  output logic [bodyWidth-1:0]               body_o
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PAY_W = formatWidth + opcodeSize + addressWidth + funcUnitCodeSize
                                + instructionCounterWidth + 2 * instMinIdWidth + 1
                                + PidSize + TidSize + 4 * regAccessPatternSize + 4 + bodyWidth;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(depth);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(depth - 1);

  // All payload fields travel as one word so an entry is written atomically.
  logic [PAY_W-1:0] pay_in;
  logic [PAY_W-1:0] pay_out;
  logic [PAY_W-1:0] mem [depth];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic full;
  logic push;
  logic pop;
  logic drop;

  assign pay_in = {instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i,
                   minID_i, numMicroOps_i, is64Bit_i, pid_i, tid_i,
                   op1rw_i, op2rw_i, op3rw_i, op4rw_i,
                   op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i};

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = valid_o & ready_i;
    // A full queue still accepts a push when the head leaves on the same edge.
    push = enable_i & (~full | pop);
    drop = enable_i & full & ~pop;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (flush_i) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        // Pointers are exactly log2(depth) bits, so the increment wraps modulo depth.
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage is not reset; empty slots are masked by valid_o on the way out.
  always_ff @(posedge clock_i) begin
    if (push && !flush_i) begin
      mem[wr_ptr] <= pay_in;
    end
  end

  assign count_o    = count_q;
  assign valid_o    = (count_q != '0);
  assign stall_o    = (count_q >= STALL_CNT);
  assign overflow_o = overflow_q;
  assign pay_out    = valid_o ? mem[rd_ptr] : '0;

  assign {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o,
          minID_o, numMicroOps_o, is64Bit_o, pid_o, tid_o,
          op1rw_o, op2rw_o, op3rw_o, op4rw_o,
          op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o} = pay_out;

endmodule
